// File: rtl/led_matrix_pkg.sv
// Shared types and helpers for the 8x8 RGB LED matrix scanner.
package led_matrix_pkg;

    localparam int MATRIX_ROWS = 8;
    localparam int MATRIX_COLS = 8;
    localparam int ROW_W       = $clog2(MATRIX_ROWS);

    typedef logic [ROW_W-1:0] row_idx_t;

    // One row of pixels; bit i of each colour plane is column i, 1 = lit.
    typedef struct packed {
        logic [MATRIX_COLS-1:0] r;
        logic [MATRIX_COLS-1:0] g;
        logic [MATRIX_COLS-1:0] b;
    } rgb_row_t;

    localparam rgb_row_t ROW_DARK = '0;

    // Column drivers sink current, so a lit pixel pulls its column low.
    function automatic rgb_row_t col_drive(input rgb_row_t px);
        rgb_row_t drv;
        drv.r = ~px.r;
        drv.g = ~px.g;
        drv.b = ~px.b;
        return drv;
    endfunction

endpackage

// File: rtl/led_frame_buffer.sv
// Double-buffered 8-row frame store: writes go to the back bank, reads come
// from the front bank, and a flip exchanges the two roles.
module led_frame_buffer
    import led_matrix_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     wr_en_i,
    input  row_idx_t wr_row_i,
    input  rgb_row_t wr_data_i,
    input  logic     flip_i,
    input  row_idx_t rd_row_i,
    output rgb_row_t rd_data_o
);

    rgb_row_t bank_q [2][MATRIX_ROWS];
    logic     front_q;

    // Write lands in the bank that is back before this cycle's flip, so a
    // write in the swap cycle ends up in the newly displayed bank.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            front_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < MATRIX_ROWS; r++) begin
                    bank_q[b][r] <= ROW_DARK;
                end
            end
        end else begin
            if (wr_en_i) begin
                bank_q[~front_q][wr_row_i] <= wr_data_i;
            end
            if (flip_i) begin
                front_q <= ~front_q;
            end
        end
    end

    assign rd_data_o = bank_q[front_q][rd_row_i];

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed refresh driver: walks the rows with a fixed dwell, blanks
// the start of each dwell, and swaps frame banks on request at frame edges.
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int ROW_HZ       = 8_000,
    parameter int BLANK_CYCLES = 50
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wr_en_i,
    input  logic [ROW_W-1:0]       wr_row_i,
    input  logic [MATRIX_COLS-1:0] wr_r_i,
    input  logic [MATRIX_COLS-1:0] wr_g_i,
    input  logic [MATRIX_COLS-1:0] wr_b_i,
    input  logic                   swap_req_i,
    output logic                   swap_ack_o,
    output logic                   frame_start_o,
    output logic [MATRIX_ROWS-1:0] led_row_o,
    output logic [MATRIX_COLS-1:0] led_col_r_o,
    output logic [MATRIX_COLS-1:0] led_col_g_o,
    output logic [MATRIX_COLS-1:0] led_col_b_o
);

    localparam int DWELL = CLK_FREQ / ROW_HZ;
    localparam int DW    = $clog2(DWELL);

    typedef logic [DW-1:0] dwell_t;

    localparam dwell_t   DWELL_LAST = dwell_t'(DWELL - 1);
    localparam dwell_t   BLANK_END  = dwell_t'(BLANK_CYCLES);
    localparam row_idx_t ROW_LAST   = row_idx_t'(MATRIX_ROWS - 1);
    localparam logic [MATRIX_ROWS-1:0] ROW0_SEL = {{(MATRIX_ROWS-1){1'b0}}, 1'b1};

    dwell_t                 dwell_q, dwell_d;
    row_idx_t               row_q, row_d;
    logic                   pend_q, pend_d;
    logic [MATRIX_ROWS-1:0] led_row_q, led_row_d;
    rgb_row_t               cols_q, cols_d;
    logic                   ack_q, ack_d;
    logic                   fs_q, fs_d;

    logic     row_end, boundary, flip, lit;
    rgb_row_t wr_px, front_px;

    assign wr_px = '{r: wr_r_i, g: wr_g_i, b: wr_b_i};

    led_frame_buffer u_fb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wr_en_i  (wr_en_i),
        .wr_row_i (wr_row_i),
        .wr_data_i(wr_px),
        .flip_i   (flip),
        .rd_row_i (row_q),
        .rd_data_o(front_px)
    );

    // Counter advance, swap arbitration and next output values from the
    // current scan position.
    always_comb begin
        row_end  = (dwell_q == DWELL_LAST);
        boundary = row_end && (row_q == ROW_LAST);
        flip     = boundary && pend_q;
        lit      = (dwell_q >= BLANK_END);

        dwell_d  = row_end ? '0 : dwell_q + dwell_t'(1);
        row_d    = row_end ? row_q + row_idx_t'(1) : row_q;
        // A request in the boundary cycle itself waits for the next frame.
        pend_d   = flip ? swap_req_i : (pend_q | swap_req_i);

        led_row_d = lit ? (ROW0_SEL << row_q) : '0;
        cols_d    = lit ? col_drive(front_px) : col_drive(ROW_DARK);
        ack_d     = flip;
        fs_d      = boundary;
    end

    // Scan state and registered LED drive.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            dwell_q   <= '0;
            row_q     <= '0;
            pend_q    <= 1'b0;
            led_row_q <= '0;
            cols_q    <= col_drive(ROW_DARK);
            ack_q     <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            dwell_q   <= dwell_d;
            row_q     <= row_d;
            pend_q    <= pend_d;
            led_row_q <= led_row_d;
            cols_q    <= cols_d;
            ack_q     <= ack_d;
            fs_q      <= fs_d;
        end
    end

    assign led_row_o     = led_row_q;
    assign led_col_r_o   = cols_q.r;
    assign led_col_g_o   = cols_q.g;
    assign led_col_b_o   = cols_q.b;
    assign swap_ack_o    = ack_q;
    assign frame_start_o = fs_q;

endmodule
